seg_scan_ctrl: RTL and testbench

//  Downstream consumer of the computer top level: takes a 32-bit value (PC, probe data) through a

---
 rtl/seg_pkg.sv | 31 +++
 rtl/seg_hex_font.sv | 12 +
 rtl/seg_scan_ctrl.sv | 112 +++++++++++
 tb/tb_seg_scan_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and the hex font for the 7-segment scan controller.
// Exposes NUM_DIG, SEG_BLANK and hex2seg (nibble -> active-low {g..a}).
package seg_pkg;

    localparam int         NUM_DIG   = 8;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [6:0] hex2seg(input logic [3:0] nib);
        logic [6:0] seg;
        unique case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_hex_font.sv
// Combinational nibble -> 7-segment glyph decoder.
// Ports: nib (4-bit hex digit in), seg ({g,f,e,d,c,b,a} active-low out).
module seg_hex_font
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = hex2seg(nib);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Double-buffered 8-digit hex scanner for the board 7-segment display.
// Ports: clk, rst (async active-low), upd_valid/upd_ready/upd_data/upd_dp
// update handshake, blank_lz, o_seg/o_sel (active-low), frame_tick.
// CLK_HZ/SCAN_HZ must be at least 2.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [4*NUM_DIG-1:0] upd_data,
    input  logic [NUM_DIG-1:0]   upd_dp,
    input  logic                 blank_lz,
    output logic [7:0]           o_seg,
    output logic [NUM_DIG-1:0]   o_sel,
    output logic                 frame_tick
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DW  = $clog2(NUM_DIG);

    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [DW-1:0] DIG_LAST  = DW'(NUM_DIG - 1);

    logic [PW-1:0]        presc;
    logic [DW-1:0]        dig;
    logic                 scan_tick;
    logic                 wrap_tick;
    logic                 accept;
    logic                 pend;
    logic [4*NUM_DIG-1:0] shadow_data;
    logic [NUM_DIG-1:0]   shadow_dp;
    logic [4*NUM_DIG-1:0] disp_data;
    logic [NUM_DIG-1:0]   disp_dp;
    logic [3:0]           nib;
    logic [6:0]           glyph;
    logic                 lz_blank;

    assign scan_tick = (presc == PRESC_MAX);
    assign wrap_tick = scan_tick && (dig == DIG_LAST);
    assign accept    = upd_valid && upd_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc      <= '0;
            dig        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap_tick;
            if (scan_tick) begin
                presc <= '0;
                dig   <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Ready is low whenever a value is pending, so accept and apply
    // can never land on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_ready   <= 1'b0;
            pend        <= 1'b0;
            shadow_data <= '0;
            shadow_dp   <= '0;
            disp_data   <= '0;
            disp_dp     <= '0;
        end else if (accept) begin
            shadow_data <= upd_data;
            shadow_dp   <= upd_dp;
            pend        <= 1'b1;
            upd_ready   <= 1'b0;
        end else begin
            upd_ready <= ~pend;
            if (wrap_tick && pend) begin
                disp_data <= shadow_data;
                disp_dp   <= shadow_dp;
                pend      <= 1'b0;
            end
        end
    end

    assign nib = disp_data[{dig, 2'b00} +: 4];

    seg_hex_font u_font (
        .nib (nib),
        .seg (glyph)
    );

    // Blank when this digit and all more significant ones are zero;
    // digit 0 is always lit so a zero value still shows "0".
    assign lz_blank = blank_lz
                   && (dig != '0)
                   && ((disp_data >> {dig, 2'b00}) == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_seg <= SEG_BLANK;
            o_sel <= '1;
        end else begin
            o_sel <= ~(NUM_DIG'(1) << dig);
            o_seg <= lz_blank ? SEG_BLANK : {~disp_dp[dig], glyph};
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl (DIV = 4).
// Reference model tracks display content per frame from cycle arithmetic.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [31:0] upd_data = '0;
    logic [7:0]  upd_dp = '0;
    logic        blank_lz = 1'b0;
    logic [7:0]  o_seg;
    logic [7:0]  o_sel;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .CLK_HZ  (1000),
        .SCAN_HZ (250)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_data   (upd_data),
        .upd_dp     (upd_dp),
        .blank_lz   (blank_lz),
        .o_seg      (o_seg),
        .o_sel      (o_sel),
        .frame_tick (frame_tick)
    );

    typedef struct {
        logic [31:0] d;
        logic [7:0]  dp;
    } item_t;

    item_t q[$];

    logic [7:0] font [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    int n_checks = 0;
    int n_errors = 0;

    // model: k = clock edges since reset release
    int          k;
    logic        m_ready;
    logic        m_pend;
    logic [31:0] m_sh_d;
    logic [7:0]  m_sh_dp;
    logic [31:0] m_disp_d;
    logic [7:0]  m_disp_dp;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (k=%0d)",
                     tag, got, exp, k);
        end
    endtask

    function automatic logic [7:0] exp_seg(input logic [31:0] d,
                                           input logic [7:0] dp,
                                           input int dg,
                                           input logic lz);
        logic [3:0] n;
        logic [7:0] f;
        if (lz && dg != 0 && (d >> (4 * dg)) == 32'd0)
            return 8'hFF;
        n = d[4*dg +: 4];
        f = font[n];
        return {~dp[dg], f[6:0]};
    endfunction

    task automatic model_reset();
        k         = 0;
        m_ready   = 1'b0;
        m_pend    = 1'b0;
        m_sh_d    = '0;
        m_sh_dp   = '0;
        m_disp_d  = '0;
        m_disp_dp = '0;
    endtask

    // one clock: called and returns at a negedge with inputs set
    task automatic step(output logic acc);
        int         dg;
        logic [7:0] es;
        logic [7:0] esel;
        logic       eft;
        logic       old_pend;
        @(posedge clk);
        dg       = (k / 4) % 8;
        es       = exp_seg(m_disp_d, m_disp_dp, dg, blank_lz);
        esel     = ~(8'd1 << dg);
        eft      = (k % 32 == 31);
        acc      = upd_valid && m_ready;
        old_pend = m_pend;
        if (acc) begin
            m_sh_d  = upd_data;
            m_sh_dp = upd_dp;
            m_pend  = 1'b1;
            m_ready = 1'b0;
        end else begin
            m_ready = !old_pend;
            if (eft && old_pend) begin
                m_disp_d  = m_sh_d;
                m_disp_dp = m_sh_dp;
                m_pend    = 1'b0;
            end
        end
        k++;
        @(negedge clk);
        chk("o_seg", 32'(o_seg), 32'(es));
        chk("o_sel", 32'(o_sel), 32'(esel));
        chk("frame_tick", 32'(frame_tick), 32'(eft));
        chk("upd_ready", 32'(upd_ready), 32'(m_ready));
    endtask

    task automatic run(input int n, input bit rnd);
        logic acc;
        item_t it;
        for (int i = 0; i < n; i++) begin
            if (rnd && q.size() == 0 && $urandom % 4 == 0) begin
                it.d  = $urandom >> (4 * ($urandom % 9));
                it.dp = ($urandom % 3 == 0) ? 8'($urandom) : 8'h00;
                q.push_back(it);
            end
            if (rnd && $urandom % 50 == 0)
                blank_lz = 1'($urandom);
            if (q.size() > 0) begin
                upd_valid = 1'b1;
                upd_data  = q[0].d;
                upd_dp    = q[0].dp;
            end else begin
                upd_valid = 1'b0;
                upd_data  = $urandom;
                upd_dp    = 8'($urandom);
            end
            step(acc);
            if (acc)
                void'(q.pop_front());
        end
    endtask

    // entered at a negedge; leaves at a negedge with rst released
    task automatic do_reset(input int n);
        #1 rst = 1'b0;
        #1;
        chk("rst_seg", 32'(o_seg), 32'hFF);
        chk("rst_sel", 32'(o_sel), 32'hFF);
        chk("rst_ready", 32'(upd_ready), 32'h0);
        chk("rst_ft", 32'(frame_tick), 32'h0);
        upd_valid = 1'b0;
        q.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_hold_seg", 32'(o_seg), 32'hFF);
        end
        rst = 1'b1;
        model_reset();
    endtask

    item_t it0;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("init_seg", 32'(o_seg), 32'hFF);
        chk("init_sel", 32'(o_sel), 32'hFF);
        chk("init_ready", 32'(upd_ready), 32'h0);
        rst = 1'b1;

        blank_lz = 1'b0;
        run(20, 1'b0);
        it0.d = 32'h1234_ABCD; it0.dp = 8'h00; q.push_back(it0);
        it0.d = 32'h8765_4321; it0.dp = 8'hA5; q.push_back(it0);
        run(110, 1'b0);

        blank_lz = 1'b1;
        it0.d = 32'h0000_00F0; it0.dp = 8'h00; q.push_back(it0);
        run(70, 1'b0);
        it0.d = 32'h0000_0000; q.push_back(it0);
        run(70, 1'b0);
        blank_lz = 1'b0;
        run(40, 1'b0);

        it0.d = 32'h0000_0300; it0.dp = 8'h04; q.push_back(it0);
        run(70, 1'b0);

        it0.d = 32'hDEAD_BEEF; it0.dp = 8'hFF; q.push_back(it0);
        run(12, 1'b0);
        do_reset(3);
        run(70, 1'b0);

        run(1500, 1'b1);
        run(13, 1'b1);
        do_reset(2);
        run(1500, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
